// File: rtl/fft_control.sv
// Sequencer for the radix-2 FFT core: load, per-level issue/drain, output.
// Optional cycle profiler enabled by defining FFT_CTRL_CYCLE_CNT_EN.
module fft_control #(
  parameter int N_LOG2   = 9,
  parameter int BFLY_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic              out_ready,
  output logic              load,
  output logic              processing,
  output logic              done,
  output logic [N_LOG2-1:0] fft_level,
  output logic [N_LOG2-1:0] butterfly_iter,
  output logic [N_LOG2-1:0] load_address,
  output logic [N_LOG2-1:0] out_address,
  output logic              rd_bank,
  output logic [N_LOG2-1:0] wr_iter,
  output logic [N_LOG2-1:0] wr_level,
  output logic              we_0,
  output logic              we_1,
  output logic              out_valid,
`ifdef FFT_CTRL_CYCLE_CNT_EN
  output logic [15:0]       cycle_count,
`endif
  output logic              busy
);

  localparam int DW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

  localparam logic [N_LOG2-1:0] LAST     = '1;
  localparam logic [N_LOG2-1:0] HALF_LAST =
    N_LOG2'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [N_LOG2-1:0] LVL_LAST = N_LOG2'(N_LOG2 - 1);
  localparam logic [DW-1:0]     DRN_LAST = DW'(BFLY_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PROC,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t            r_state;
  logic              r_load;
  logic              r_proc;
  logic              r_done;
  logic              r_busy;
  logic              r_out_valid;
  logic [N_LOG2-1:0] r_level;
  logic [N_LOG2-1:0] r_iter;
  logic [N_LOG2-1:0] r_load_addr;
  logic [N_LOG2-1:0] r_out_addr;
  logic [DW-1:0]     r_drain;

  logic              r_iss  [BFLY_LAT];
  logic [N_LOG2-1:0] r_it_d [BFLY_LAT];
  logic [N_LOG2-1:0] r_lv_d [BFLY_LAT];

  logic              w_wr;

  // Main sequencer: state, counters and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_load      <= 1'b0;
      r_proc      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_level     <= '0;
      r_iter      <= '0;
      r_load_addr <= '0;
      r_out_addr  <= '0;
      r_drain     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (r_load_addr == LAST) begin
              r_load_addr <= '0;
              r_state     <= S_PROC;
              r_load      <= 1'b0;
              r_proc      <= 1'b1;
            end else begin
              r_load_addr <= r_load_addr + 1'b1;
            end
          end
        end
        S_PROC: begin
          if (r_iter == HALF_LAST) begin
            r_iter  <= '0;
            r_drain <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_iter <= r_iter + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_drain == DRN_LAST) begin
            r_drain <= '0;
            if (r_level == LVL_LAST) begin
              r_level <= '0;
              r_state <= S_OUT;
              r_proc  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_level <= r_level + 1'b1;
              r_state <= S_PROC;
            end
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        S_OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_addr == LAST) begin
              r_out_addr <= '0;
              r_state    <= S_IDLE;
              r_done     <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_out_addr <= r_out_addr + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write-side delay line matching the butterfly read-to-write latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BFLY_LAT; i++) begin
        r_iss[i]  <= 1'b0;
        r_it_d[i] <= '0;
        r_lv_d[i] <= '0;
      end
    end else begin
      r_iss[0]  <= (r_state == S_PROC);
      r_it_d[0] <= r_iter;
      r_lv_d[0] <= r_level;
      for (int i = 1; i < BFLY_LAT; i++) begin
        r_iss[i]  <= r_iss[i-1];
        r_it_d[i] <= r_it_d[i-1];
        r_lv_d[i] <= r_lv_d[i-1];
      end
    end
  end

`ifdef FFT_CTRL_CYCLE_CNT_EN
  logic [15:0] r_cyc;

  // Frame profiler: cleared on start accept, frozen while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cyc <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_cyc <= '0;
    end else if (r_busy) begin
      r_cyc <= r_cyc + 1'b1;
    end
  end

  assign cycle_count = r_cyc;
`endif

  assign w_wr = r_iss[BFLY_LAT-1];

  assign load           = r_load;
  assign processing     = r_proc;
  assign done           = r_done;
  assign busy           = r_busy;
  assign out_valid      = r_out_valid;
  assign fft_level      = r_level;
  assign butterfly_iter = r_iter;
  assign load_address   = r_load_addr;
  assign out_address    = r_out_addr;
  assign rd_bank        = r_level[0];
  assign wr_iter        = r_it_d[BFLY_LAT-1];
  assign wr_level       = r_lv_d[BFLY_LAT-1];

  // Writes land in the bank opposite the one read at that level.
  assign we_0 = (r_load & in_valid) | (w_wr & wr_level[0]);
  assign we_1 = w_wr & ~wr_level[0];

endmodule
